// File: rtl/sram_read_unpack_if.sv
// Bundle between the SRAM read unpacker and its surroundings: the control
// strobes, the address-generator request/data pair and the byte stream.
interface sram_read_unpack_if;
  logic        start;
  logic [15:0] word_count;
  logic        read_next;
  logic [31:0] read_data;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        out_ready;
  logic        out_last;
  logic        busy;
  logic        done;

  // Environment side: starts transfers, models the SRAM, consumes bytes.
  modport master (
    output start, word_count, read_data, out_ready,
    input  read_next, out_data, out_valid, out_last, busy, done
  );

  // Unpacker side.
  modport slave (
    input  start, word_count, read_data, out_ready,
    output read_next, out_data, out_valid, out_last, busy, done
  );
endinterface

// File: rtl/sram_read_unpack.sv
// SRAM read unpacker: paces the address generator with read_next requests,
// captures read_data after a fixed latency into a small word FIFO and emits
// the words as a little-endian byte stream.
//
// state | meaning
// IDLE  | waiting for start; a zero-length start only pulses done
// FETCH | issuing requests while FIFO credit allows
// DRAIN | all requests issued, streaming the remaining bytes
// DONE  | one-cycle done pulse, then back to IDLE
module sram_read_unpack #(
  parameter int DEPTH        = 4,
  parameter int READ_LATENCY = 1
) (
  input logic          clk,
  input logic          rst,
  sram_read_unpack_if.slave bus
);
  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {IDLE, FETCH, DRAIN, DONE} state_t;

  state_t                  state_q, state_d;
  logic [15:0]             count_q, count_d;
  logic [15:0]             issued_q, issued_d;
  logic [15:0]             popped_q, popped_d;
  logic [AW:0]             occ_q, occ_d;
  logic [AW:0]             inflight_q, inflight_d;
  logic [AW-1:0]           wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]           rd_ptr_q, rd_ptr_d;
  logic [1:0]              byte_q, byte_d;
  logic [READ_LATENCY-1:0] tok_q, tok_d;
  logic                    read_next_q, read_next_d;
  logic                    done_q, done_d;
  logic [31:0]             mem_q [DEPTH];

  logic [AW+1:0] credit_used;
  logic          issue, push, pop, hs, fifo_valid, head_last;
  logic [31:0]   head;
  logic [7:0]    head_byte;

  // Next-state computation for the FSM, credit counters and FIFO pointers.
  always_comb begin
    fifo_valid  = (occ_q != '0);
    head        = mem_q[rd_ptr_q];
    hs          = fifo_valid && bus.out_ready;
    pop         = hs && (byte_q == 2'd3);
    push        = tok_q[READ_LATENCY-1];
    head_last   = ((popped_q + 16'd1) == count_q);
    // Words already in the FIFO plus words requested but not yet captured
    // must never exceed DEPTH, so a push always has room.
    credit_used = {1'b0, occ_q} + {1'b0, inflight_q};
    issue       = (state_q == FETCH) && (issued_q < count_q) &&
                  (credit_used < (AW+2)'(DEPTH));

    state_d     = state_q;
    count_d     = count_q;
    issued_d    = issued_q;
    popped_d    = popped_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    byte_d      = byte_q;
    read_next_d = issue;
    done_d      = 1'b0;

    // The token pipe follows the registered request, so a token exits in the
    // cycle where the SRAM presents the matching word.
    tok_d    = '0;
    tok_d[0] = read_next_q;
    for (int i = 1; i < READ_LATENCY; i++) tok_d[i] = tok_q[i-1];

    occ_d      = occ_q + (AW+1)'(push) - (AW+1)'(pop);
    inflight_d = inflight_q + (AW+1)'(issue) - (AW+1)'(push);

    if (issue) issued_d = issued_q + 16'd1;
    if (push)  wr_ptr_d = wr_ptr_q + AW'(1);
    if (hs)    byte_d   = byte_q + 2'd1;
    if (pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
      popped_d = popped_q + 16'd1;
    end

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          if (bus.word_count != 16'd0) begin
            count_d  = bus.word_count;
            issued_d = 16'd0;
            popped_d = 16'd0;
            state_d  = FETCH;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      FETCH, DRAIN: begin
        if (pop && head_last) begin
          state_d = DONE;
          done_d  = 1'b1;
        end else if (state_q == FETCH && issued_q == count_q) begin
          state_d = DRAIN;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Register all control state; reset discards any transfer in progress.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      count_q     <= '0;
      issued_q    <= '0;
      popped_q    <= '0;
      occ_q       <= '0;
      inflight_q  <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      byte_q      <= '0;
      tok_q       <= '0;
      read_next_q <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      issued_q    <= issued_d;
      popped_q    <= popped_d;
      occ_q       <= occ_d;
      inflight_q  <= inflight_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      byte_q      <= byte_d;
      tok_q       <= tok_d;
      read_next_q <= read_next_d;
      done_q      <= done_d;
    end
  end

  // FIFO storage; contents are don't-care while the occupancy says empty.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= bus.read_data;
  end

  // Byte select from the head word, least significant byte first.
  always_comb begin
    head_byte = 8'h00;
    case (byte_q)
      2'd0: head_byte = head[7:0];
      2'd1: head_byte = head[15:8];
      2'd2: head_byte = head[23:16];
      2'd3: head_byte = head[31:24];
      default: head_byte = 8'h00;
    endcase
  end

  assign bus.read_next = read_next_q;
  assign bus.out_valid = fifo_valid;
  assign bus.out_data  = fifo_valid ? head_byte : 8'h00;
  assign bus.out_last  = fifo_valid && (byte_q == 2'd3) && head_last;
  assign bus.busy      = (state_q != IDLE);
  assign bus.done      = done_q;
endmodule

// File: tb/tb_sram_read_unpack.sv
// Directed bench for sram_read_unpack: one instance at READ_LATENCY=1 and one
// at READ_LATENCY=3, each fed by its own SRAM model.
module tb_sram_read_unpack;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        sel;
  logic        start_drv;
  logic [15:0] wc_drv;
  logic        ready_drv;
  logic        addr_clr;

  int checks = 0;
  int errors = 0;

  sram_read_unpack_if if1 ();
  sram_read_unpack_if if3 ();

  sram_read_unpack #(.DEPTH(4), .READ_LATENCY(1)) u_dut1 (
    .clk(clk), .rst(rst), .bus(if1.slave)
  );
  sram_read_unpack #(.DEPTH(4), .READ_LATENCY(3)) u_dut3 (
    .clk(clk), .rst(rst), .bus(if3.slave)
  );

  assign if1.start      = !sel && start_drv;
  assign if3.start      = sel && start_drv;
  assign if1.word_count = wc_drv;
  assign if3.word_count = wc_drv;
  assign if1.out_ready  = ready_drv;
  assign if3.out_ready  = ready_drv;

  // Word returned for the a-th request of a transfer: byte k = (4a+k+1)*0x11.
  function automatic logic [31:0] word_of(input int a);
    logic [31:0] w;
    for (int k = 0; k < 4; k++) w[8*k +: 8] = 8'((4*a + k + 1) * 17);
    return w;
  endfunction

  // SRAM models: address counters advance on read_next; data appears after
  // the matching latency, garbage otherwise.
  logic [15:0] addr1, addr3;
  int          dn1, dn3;
  logic [31:0] pipe1;
  logic [31:0] pipe3 [3];

  always @(posedge clk) begin
    if (addr_clr) begin
      addr1 <= '0; addr3 <= '0; dn1 <= 0; dn3 <= 0;
    end else begin
      if (if1.read_next) addr1 <= addr1 + 16'd1;
      if (if3.read_next) addr3 <= addr3 + 16'd1;
      if (if1.done) dn1 <= dn1 + 1;
      if (if3.done) dn3 <= dn3 + 1;
    end
    pipe1    <= if1.read_next ? word_of(int'(addr1)) : 32'hDEADBEEF;
    pipe3[0] <= if3.read_next ? word_of(int'(addr3)) : 32'hDEADBEEF;
    pipe3[1] <= pipe3[0];
    pipe3[2] <= pipe3[1];
  end

  assign if1.read_data = pipe1;
  assign if3.read_data = pipe3[2];

  logic [7:0]  o_data;
  logic        o_valid, o_last, o_busy, o_done, o_rn;
  logic [15:0] o_rncnt;
  int          o_dncnt;
  assign o_data  = sel ? if3.out_data  : if1.out_data;
  assign o_valid = sel ? if3.out_valid : if1.out_valid;
  assign o_last  = sel ? if3.out_last  : if1.out_last;
  assign o_busy  = sel ? if3.busy      : if1.busy;
  assign o_done  = sel ? if3.done      : if1.done;
  assign o_rn    = sel ? if3.read_next : if1.read_next;
  assign o_rncnt = sel ? addr3 : addr1;
  assign o_dncnt = sel ? dn3 : dn1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_valid"}, o_valid, 1'b0);
    check({tag, "_data"},  o_data,  8'h00);
    check({tag, "_last"},  o_last,  1'b0);
    check({tag, "_busy"},  o_busy,  1'b0);
    check({tag, "_done"},  o_done,  1'b0);
    check({tag, "_rn"},    o_rn,    1'b0);
  endtask

  task automatic do_start(input logic [15:0] wc);
    addr_clr  = 1'b1;
    start_drv = 1'b1;
    wc_drv    = wc;
    @(negedge clk);
    addr_clr  = 1'b0;
    start_drv = 1'b0;
  endtask

  // Consume nwords*4 bytes; mode 0 keeps out_ready high, mode 1 toggles it.
  task automatic collect(input string tag, input int nwords, input int mode, input int budget);
    int          got = 0;
    int          cyc = 0;
    logic        stalled = 1'b0;
    logic [7:0]  held = 8'h00;
    logic [31:0] ew;
    while (got < nwords*4 && cyc < budget) begin
      ready_drv = (mode == 0) ? 1'b1 : ((cyc % 2) == 0);
      if (stalled) begin
        check({tag, "_stall_valid"}, o_valid, 1'b1);
        check({tag, "_stall_data"},  o_data,  held);
      end
      stalled = 1'b0;
      if (o_valid && ready_drv) begin
        ew = word_of(got / 4);
        check({tag, "_byte"}, o_data, ew[8*(got%4) +: 8]);
        check({tag, "_last"}, o_last, (got == nwords*4 - 1));
        got++;
      end else if (o_valid) begin
        held    = o_data;
        stalled = 1'b1;
      end
      @(negedge clk);
      cyc++;
    end
    if (got < nwords*4) check({tag, "_timeout_bytes"}, got, nwords*4);
  endtask

  initial begin
    rst = 1'b1; sel = 1'b0; start_drv = 1'b0; wc_drv = '0;
    ready_drv = 1'b0; addr_clr = 1'b1;

    // Reset and idle.
    repeat (3) @(negedge clk);
    rst = 1'b0;
    addr_clr = 1'b0;
    @(negedge clk);
    check_idle_outputs("reset");

    // Zero-length start: done next cycle, no requests.
    do_start(16'd0);
    check("zero_done", o_done, 1'b1);
    check("zero_busy", o_busy, 1'b0);
    @(negedge clk);
    check("zero_done_clear", o_done, 1'b0);
    repeat (5) @(negedge clk);
    check("zero_no_rn", o_rncnt, 16'd0);

    // Basic two-word transfer: 11 22 33 44 55 66 77 88.
    ready_drv = 1'b1;
    do_start(16'd2);
    check("basic_busy", o_busy, 1'b1);
    collect("basic", 2, 0, 200);
    check("basic_done", o_done, 1'b1);
    @(negedge clk);
    check("basic_done_clear", o_done, 1'b0);
    check("basic_idle", o_busy, 1'b0);
    check("basic_rn", o_rncnt, 16'd2);

    // Backpressure: credit stops issue at DEPTH words.
    ready_drv = 1'b0;
    do_start(16'd8);
    repeat (30) @(negedge clk);
    check("bp_rn_cap", o_rncnt, 16'd4);
    check("bp_valid", o_valid, 1'b1);
    check("bp_head", o_data, 8'h11);
    check("bp_busy", o_busy, 1'b1);
    collect("bp", 8, 0, 400);
    check("bp_done", o_done, 1'b1);
    check("bp_rn", o_rncnt, 16'd8);
    @(negedge clk);
    check("bp_valid_end", o_valid, 1'b0);

    // Latency 3 with toggling out_ready.
    sel = 1'b1;
    do_start(16'd5);
    collect("lat3", 5, 1, 400);
    check("lat3_done", o_done, 1'b1);
    check("lat3_rn", o_rncnt, 16'd5);
    ready_drv = 1'b0;
    @(negedge clk);
    check("lat3_idle", o_busy, 1'b0);

    // Reset mid-transfer after the third request, words in flight.
    do_start(16'd6);
    begin
      int w = 0;
      while (!(o_rn && o_rncnt == 16'd2) && w < 50) begin
        @(negedge clk);
        w++;
      end
      check("rstmid_wait", (w < 50), 1'b1);
    end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_idle_outputs("rstmid");
    repeat (10) @(negedge clk);
    check("rstmid_no_capture", o_valid, 1'b0);
    check("rstmid_no_done", o_dncnt, 0);
    check("rstmid_idle", o_busy, 1'b0);
    ready_drv = 1'b1;
    do_start(16'd1);
    collect("rstmid_new", 1, 0, 100);
    check("rstmid_new_done", o_done, 1'b1);
    check("rstmid_new_rn", o_rncnt, 16'd1);

    // Start while busy is ignored.
    sel = 1'b0;
    ready_drv = 1'b0;
    @(negedge clk);
    do_start(16'd3);
    @(negedge clk);
    start_drv = 1'b1;
    wc_drv    = 16'd9;
    @(negedge clk);
    start_drv = 1'b0;
    collect("busy_start", 3, 0, 200);
    check("busy_start_done", o_done, 1'b1);
    repeat (20) @(negedge clk);
    check("busy_start_rn", o_rncnt, 16'd3);
    check("busy_start_idle", o_busy, 1'b0);
    check("busy_start_no_extra", o_valid, 1'b0);
    check("busy_start_one_done", o_dncnt, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "watchdog");
  end
endmodule
